// File: rtl/fetch_decode_if.sv
// rtl/fetch_decode_if.sv - instruction-memory and execution handshake bundle for fetch_decode
interface fetch_decode_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       ready;
  logic       exec_done;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;

  // fetch/decode stage side
  modport master (
    output mem_req, mem_addr, ready, opcode, src, dest,
    input  mem_ack, mem_data, exec_done
  );

  // memory and execution-unit side
  modport slave (
    input  mem_req, mem_addr, ready, opcode, src, dest,
    output mem_ack, mem_data, exec_done
  );
endinterface

// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - 8-bit core fetch/decode stage; optional macro FETCH_ILLEGAL_TRAP_EN traps illegal opcodes
module fetch_decode #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic           clk,
  input  logic           reset,
  fetch_decode_if.master bus,
  output logic [7:0]     pc,
  output logic           halted,
  output logic           error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    TARGET = 3'd3,
    ISSUE  = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] ir;
  logic       mem_req;
  logic       ready;

  // state register, aborts to IDLE immediately on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state: memory waits hold FETCH/TARGET, execution waits hold ISSUE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   state_next = FETCH;
      FETCH:  if (bus.mem_ack) state_next = DECODE;
      DECODE: begin
        case (ir[7:4])
          4'h1, 4'h2, 4'h3: state_next = ISSUE;
          4'h4:             state_next = TARGET;
          4'hF:             state_next = HALT;
          4'h0:             state_next = FETCH;
`ifdef FETCH_ILLEGAL_TRAP_EN
          default:          state_next = HALT;
`else
          default:          state_next = FETCH;
`endif
        endcase
      end
      TARGET: if (bus.mem_ack) state_next = FETCH;
      ISSUE:  if (bus.exec_done) state_next = FETCH;
      HALT:   state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded purely from the registered state
  always_comb begin
    mem_req = 1'b0;
    ready   = 1'b0;
    halted  = 1'b0;
    case (state)
      FETCH, TARGET: mem_req = 1'b1;
      ISSUE:         ready   = 1'b1;
      HALT:          halted  = 1'b1;
      default:       ;
    endcase
  end

  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = pc;
  assign bus.ready    = ready;
  assign bus.opcode   = ir[7:4];
  assign bus.src      = ir[3:2];
  assign bus.dest     = ir[1:0];

  // pc/ir update: opcode byte advances pc, jump target byte replaces it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
      ir <= 8'h00;
    end else if (state == FETCH && bus.mem_ack) begin
      ir <= bus.mem_data;
      pc <= pc + 8'd1;
    end else if (state == TARGET && bus.mem_ack) begin
      pc <= bus.mem_data;
    end
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  // sticky illegal-opcode flag, set as DECODE hands off to HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (state == DECODE && ir[7:4] >= 4'h5 && ir[7:4] <= 4'hE) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - scoreboard bench for fetch_decode with an instruction-level reference model
module tb_fetch_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc, pc2;
  logic       halted, error, halted2, error2;

  always #5 clk = ~clk;

  fetch_decode_if bus ();
  fetch_decode_if bus2 ();

  fetch_decode #(.RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pc(pc), .halted(halted), .error(error)
  );

  fetch_decode #(.RESET_PC(8'hFF)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .pc(pc2), .halted(halted2), .error(error2)
  );

  // second instance: zero-wait memory full of NOPs, never executes anything
  assign bus2.mem_ack   = bus2.mem_req;
  assign bus2.mem_data  = 8'h00;
  assign bus2.exec_done = 1'b0;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] src;
    logic [1:0] dest;
    logic [7:0] pc;
  } issue_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem [256];
  issue_t     issue_q [$];
  logic [7:0] fetch_q [$];
  bit         exp_halt, exp_err;
  int         wait_min, wait_max, done_pct;
  bit         manual, manual_done;

  logic       tr_req [16];
  logic       tr_ready [16];
  logic       tr_halt [16];
  logic       tr_err [16];
  logic [7:0] tr_addr [16];
  logic [7:0] tr_pc [16];
  logic       tr_req2 [16];
  logic [7:0] tr_addr2 [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction-set level model: walk the program and list every memory read and every issue
  task automatic build_model(input logic [7:0] start);
    logic [7:0] p;
    logic [7:0] b;
    int         n;
    issue_t     e;
    fetch_q.delete();
    issue_q.delete();
    exp_halt = 1'b0;
    exp_err  = 1'b0;
    p = start;
    n = 0;
    while (n < 40 && !exp_halt) begin
      b = mem[p];
      fetch_q.push_back(p);
      p = p + 8'd1;
      n++;
      case (b[7:4])
        4'h1, 4'h2, 4'h3: begin
          e.op = b[7:4]; e.src = b[3:2]; e.dest = b[1:0]; e.pc = p;
          issue_q.push_back(e);
        end
        4'h0: ;
        4'h4: if (n < 40) begin
          fetch_q.push_back(p);
          p = mem[p];
          n++;
        end
        4'hF: exp_halt = 1'b1;
        default: begin
`ifdef FETCH_ILLEGAL_TRAP_EN
          exp_halt = 1'b1;
          exp_err  = 1'b1;
`endif
        end
      endcase
    end
  endtask

  // memory and execution responders, driven just after each rising edge
  bit busy, last_hs;
  int left;
  always @(posedge clk) begin
    #1;
    if (!reset || !bus.mem_req) begin
      busy = 1'b0;
      last_hs = 1'b0;
      bus.mem_ack  = 1'($urandom);
      bus.mem_data = 8'($urandom);
    end else begin
      if (!busy || last_hs) begin
        busy = 1'b1;
        left = int'($urandom_range(wait_max, wait_min));
      end
      if (left == 0) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = mem[bus.mem_addr];
        last_hs = 1'b1;
      end else begin
        left--;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'($urandom);
        last_hs = 1'b0;
      end
    end
    if (manual) bus.exec_done = manual_done;
    else if (bus.ready) bus.exec_done = (int'($urandom_range(99, 0)) < done_pct);
    else bus.exec_done = 1'($urandom);
  end

  // monitor: pops the scoreboard on every handshake and checks handshake rules
  logic       prev_req, prev_ack, prev_ready, prev_done;
  logic [7:0] prev_addr, prev_pc;
  logic [7:0] prev_ir;
  always @(negedge clk) begin
    logic [7:0] a;
    issue_t     e;
    if (!reset) begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_ready = 1'b0; prev_done = 1'b0;
    end else begin
      if (prev_req && !prev_ack)
        check("wait_hold", {bus.mem_req, bus.mem_addr, pc}, {1'b1, prev_addr, prev_pc});
      if (prev_ready && !prev_done)
        check("ready_hold", {bus.ready, bus.opcode, bus.src, bus.dest}, {1'b1, prev_ir});
      if (prev_ready && prev_done)
        check("ready_drop", {bus.ready, bus.mem_req}, 2'b01);
      if (bus.mem_req && bus.mem_ack) begin
        if (fetch_q.size() > 0) begin
          a = fetch_q.pop_front();
          check("fetch_addr", bus.mem_addr, a);
        end else if (exp_halt) begin
          checks++; errors++;
          $display("FAIL extra_fetch: got addr %0h expected no read", bus.mem_addr);
        end
      end
      if (bus.ready && !prev_ready) begin
        if (issue_q.size() > 0) begin
          e = issue_q.pop_front();
          check("issue", {bus.opcode, bus.src, bus.dest, pc}, e);
        end else if (exp_halt) begin
          checks++; errors++;
          $display("FAIL extra_issue: got opcode %0h expected no issue", bus.opcode);
        end
      end
      prev_req   = bus.mem_req;
      prev_ack   = bus.mem_ack;
      prev_addr  = bus.mem_addr;
      prev_pc    = pc;
      prev_ready = bus.ready;
      prev_done  = bus.exec_done;
      prev_ir    = {bus.opcode, bus.src, bus.dest};
    end
  end

  task automatic fill(input logic [7:0] b);
    for (int i = 0; i < 256; i++) mem[i] = b;
  endtask

  task automatic fill_random();
    int r;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(15, 0));
      if (r < 2)       mem[i] = {4'h0, 4'($urandom)};
      else if (r < 9)  mem[i] = {4'(int'($urandom_range(3, 1))), 4'($urandom)};
      else if (r < 11) mem[i] = {4'h4, 4'($urandom)};
      else if (r < 12) mem[i] = {4'hF, 4'($urandom)};
      else             mem[i] = 8'($urandom);
    end
  endtask

  task automatic start_episode();
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    build_model(8'h00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic trace(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tr_req[k] = bus.mem_req;  tr_addr[k] = bus.mem_addr; tr_ready[k] = bus.ready;
      tr_pc[k] = pc;            tr_halt[k] = halted;       tr_err[k] = error;
      tr_req2[k] = bus2.mem_req; tr_addr2[k] = bus2.mem_addr;
    end
  endtask

  task automatic finish_episode();
    int t;
    t = 0;
    while ((fetch_q.size() > 0 || issue_q.size() > 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", fetch_q.size() + issue_q.size(), 0);
    if (exp_halt) begin
      repeat (3) @(negedge clk);
      check("halt_state", {halted, error, bus.mem_req, bus.ready}, {1'b1, exp_err, 1'b0, 1'b0});
    end
  endtask

  initial begin
    int t;
    reset = 1'b0;
    wait_min = 0; wait_max = 0; done_pct = 100;
    manual = 1'b0; manual_done = 1'b0;
    fill(8'hF0);
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.mem_req, bus.ready, halted, error, bus.opcode, bus.src, bus.dest, pc}, 0);
    check("reset_pc2", pc2, 8'hFF);

    // ALU issue, hold while exec_done low, release on pulse; second instance wraps FF -> 00
    fill(8'hF0);
    mem[8'h00] = 8'h16;
    manual = 1'b1; manual_done = 1'b0;
    start_episode();
    trace(3);
    check("first_req", {tr_req[1], tr_addr[1]}, {1'b1, 8'h00});
    check("ready_rise", {tr_ready[2], tr_ready[3], tr_pc[3]}, {1'b0, 1'b1, 8'h01});
    check("wrap_first", {tr_req2[1], tr_addr2[1]}, {1'b1, 8'hFF});
    check("wrap_next", {tr_req2[3], tr_addr2[3], halted2, error2}, {1'b1, 8'h00, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ready_wait", bus.ready, 1'b1);
    end
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    @(negedge clk);
    check("after_done", {bus.ready, bus.mem_req, bus.mem_addr}, {1'b0, 1'b1, 8'h01});
    manual = 1'b0;
    finish_episode();

    // jump: no issue before the target fetch
    fill(8'hF0);
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h80; mem[8'h80] = 8'h21;
    start_episode();
    trace(6);
    check("jmp_target", {tr_req[4], tr_addr[4]}, {1'b1, 8'h80});
    check("jmp_no_ready", {tr_ready[1], tr_ready[2], tr_ready[3], tr_ready[4], tr_ready[5], tr_ready[6]}, 6'b000001);
    finish_episode();

    // three wait states on every read
    wait_min = 3; wait_max = 3;
    fill(8'hF0);
    mem[8'h00] = 8'h2B;
    start_episode();
    trace(5);
    check("wait_req", {tr_req[1], tr_req[2], tr_req[3], tr_req[4], tr_req[5]}, 5'b11110);
    check("wait_addr", {tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]}, 32'h0);
    check("wait_pc", {tr_pc[1], tr_pc[4], tr_pc[5]}, {8'h00, 8'h00, 8'h01});
    finish_episode();
    wait_min = 0; wait_max = 0;

    // illegal opcode
    fill(8'hF0);
    mem[8'h00] = 8'h50;
    start_episode();
    trace(3);
`ifdef FETCH_ILLEGAL_TRAP_EN
    check("illegal_trap", {tr_halt[3], tr_err[3], tr_req[3]}, 3'b110);
`else
    check("illegal_nop", {tr_req[3], tr_addr[3], tr_err[3]}, {1'b1, 8'h01, 1'b0});
`endif
    finish_episode();

    // asynchronous reset while an instruction is issued
    fill(8'hF0);
    mem[8'h00] = 8'h16;
    manual = 1'b1; manual_done = 1'b0;
    start_episode();
    t = 0;
    while (!bus.ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("reach_ready", bus.ready, 1'b1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_reset", {bus.ready, bus.mem_req, halted, bus.opcode, pc}, 0);
    check("async_reset_pc2", pc2, 8'hFF);
    manual = 1'b0;
    fetch_q.delete();
    issue_q.delete();

    // randomized programs, waits and execution latency
    for (int ep = 0; ep < 10; ep++) begin
      wait_min = 0;
      wait_max = int'($urandom_range(2, 0));
      done_pct = int'($urandom_range(100, 20));
      fill_random();
      start_episode();
      finish_episode();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
